// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default datapath width, the canonical NOP encoding
// and the program-counter type used across pipeline stages.
package pipeline_pkg;

   localparam int unsigned DEFAULT_XLEN = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [DEFAULT_XLEN-1:0] pc_t;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction prefetch queue: synchronous FIFO holding an instruction word and its PC
// per entry. State updates on the falling clock edge to match the rest of the pipeline.
// A synchronous flush (or reset) empties the queue; storage itself is not cleared.
module ifq_fifo
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN  = DEFAULT_XLEN,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic                     flush,
   input  logic                     push,
   input  logic [XLEN-1:0]          push_data,
   input  logic [XLEN-1:0]          push_pc,
   input  logic                     pop,
   output logic                     head_valid,
   output logic [XLEN-1:0]          head_data,
   output logic [XLEN-1:0]          head_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [XLEN-1:0] data_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];

   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW:0]   count_q;

   logic full;
   logic do_push;
   logic do_pop;

   // Qualify push/pop: never pop empty, never push into a full queue unless it also drains.
   always_comb begin
      full    = (count_q == (AW+1)'(DEPTH));
      do_pop  = pop && (count_q != '0);
      do_push = push && (!full || do_pop);
   end

   // Pointer and occupancy update; flush has priority over push and pop.
   always_ff @(negedge clk) begin
      if (!clrn || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; written only on an accepted push outside flush/reset.
   always_ff @(negedge clk) begin
      if (clrn && !flush && do_push) begin
         data_mem[wr_ptr_q] <= push_data;
         pc_mem[wr_ptr_q]   <= push_pc;
      end
   end

   // Head-of-queue view.
   always_comb begin
      head_valid = (count_q != '0);
      head_data  = data_mem[rd_ptr_q];
      head_pc    = pc_mem[rd_ptr_q];
      count      = count_q;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: issues one sequential fetch per cycle while the queue
// plus the single in-flight request has room, queues responses with their PCs and hands
// them to decode in order. A redirect flushes everything and restarts at the new target.
// Optional feature macro: IFQ_BYPASS_EN -- an arriving response drives the outputs
// combinationally when the queue is empty.
module if_prefetch
   import pipeline_pkg::*;
#(
   parameter int unsigned      XLEN     = DEFAULT_XLEN,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              clrn,
   output logic [XLEN-1:0]   imemaddr,
   output logic              imemreq,
   output logic              imemclk,
   input  logic [XLEN-1:0]   imemdataout,
   output logic              instr_valid,
   output logic [XLEN-1:0]   instr,
   output logic [XLEN-1:0]   instr_pc,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc
);

   localparam int unsigned     AW       = $clog2(DEPTH);
   localparam logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_INSTR);

   logic [XLEN-1:0] fpc_q;
   logic [XLEN-1:0] fpc_d;
   logic            inflight_q;
   logic [XLEN-1:0] req_pc_q;

   logic            issue;
   logic [AW+1:0]   occupancy;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_valid;
   logic [XLEN-1:0] fifo_data;
   logic [XLEN-1:0] fifo_pc;
   logic [AW:0]     fifo_count;

   // Redirect target low bits are dropped; fetch addresses stay word aligned.
   logic [1:0] unused_rpc_bits;
   assign unused_rpc_bits = redirect_pc[1:0];

   assign imemclk = clk;

   ifq_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_ifq_fifo (
      .clk        (clk),
      .clrn       (clrn),
      .flush      (redirect),
      .push       (fifo_push),
      .push_data  (imemdataout),
      .push_pc    (req_pc_q),
      .pop        (fifo_pop),
      .head_valid (fifo_valid),
      .head_data  (fifo_data),
      .head_pc    (fifo_pc),
      .count      (fifo_count)
   );

   // Issue only when the queue can absorb every outstanding word; a pop this cycle
   // is deliberately not credited so the decision never depends on instr_ready.
   always_comb begin
      occupancy = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight_q};
      issue     = clrn && !redirect && (occupancy < (AW+2)'(DEPTH));
      imemreq   = issue;
      imemaddr  = fpc_q;
   end

   // Next fetch address: redirect wins, otherwise advance by one word per issued request.
   always_comb begin
      fpc_d = fpc_q;
      if (redirect) begin
         fpc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (issue) begin
         fpc_d = fpc_q + XLEN'(4);
      end
   end

   // Fetch PC and in-flight tracking; a redirect leaves nothing outstanding since
   // no request issues in the redirect cycle.
   always_ff @(negedge clk) begin
      if (!clrn) begin
         fpc_q      <= {RESET_PC[XLEN-1:2], 2'b00};
         inflight_q <= 1'b0;
         req_pc_q   <= '0;
      end else begin
         fpc_q      <= fpc_d;
         inflight_q <= issue;
         if (issue) req_pc_q <= fpc_q;
      end
   end

`ifdef IFQ_BYPASS_EN
   logic bypass;
`endif

   // Queue control and decode-facing outputs; outputs read as NOP/invalid in reset.
   always_comb begin
      fifo_push   = inflight_q && !redirect;
      fifo_pop    = clrn && !redirect && fifo_valid && instr_ready;
      instr_valid = 1'b0;
      instr       = NOP_WORD;
      instr_pc    = '0;
`ifdef IFQ_BYPASS_EN
      bypass = clrn && inflight_q && !fifo_valid;
      if (bypass) begin
         instr_valid = 1'b1;
         instr       = imemdataout;
         instr_pc    = req_pc_q;
         // Word consumed straight off the bus never occupies a queue slot.
         if (instr_ready && !redirect) fifo_push = 1'b0;
      end
`endif
      if (clrn && fifo_valid) begin
         instr_valid = 1'b1;
         instr       = fifo_data;
         instr_pc    = fifo_pc;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch (default build, queue bypass disabled).
// The bench plays instruction memory: a word requested in one cycle is presented
// during the next cycle, with random junk on the bus otherwise.
module tb_if_prefetch;
   import pipeline_pkg::*;

   localparam int  DEPTH    = 4;
   localparam pc_t RESET_PC = 32'h0000_0000;
   localparam pc_t NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic clrn;
   logic redirect;
   logic instr_ready;
   pc_t  redirect_pc;
   pc_t  imemdataout;
   pc_t  imemaddr;
   logic imemreq;
   logic imemclk;
   logic instr_valid;
   pc_t  instr;
   pc_t  instr_pc;

   int n_checks = 0;
   int n_fail   = 0;

   // Observed outputs, sampled mid-cycle (rising edge; state moves on falling edge).
   logic o_req, o_valid, o_imemclk;
   pc_t  o_addr, o_instr, o_pc;

   // Reference model state and its per-cycle expectations.
   pc_t  mq[$];
   bit   m_infl = 1'b0;
   pc_t  m_infl_pc = '0;
   pc_t  m_fpc = '0;
   logic m_req, m_valid;
   pc_t  m_addr, m_pc, m_instr;

   if_prefetch #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .clrn        (clrn),
      .imemaddr    (imemaddr),
      .imemreq     (imemreq),
      .imemclk     (imemclk),
      .imemdataout (imemdataout),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic pc_t word_of(input pc_t a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   // One pipeline cycle: sample outputs and model expectations, cross the falling
   // edge, advance the model and present the memory response for the next cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      o_req     = imemreq;
      o_addr    = imemaddr;
      o_valid   = instr_valid;
      o_instr   = instr;
      o_pc      = instr_pc;
      o_imemclk = imemclk;
      m_req   = clrn && !redirect && ((mq.size() + int'(m_infl)) < DEPTH);
      m_addr  = m_fpc;
      m_valid = clrn && (mq.size() > 0);
      m_pc    = m_valid ? mq[0] : '0;
      m_instr = m_valid ? word_of(mq[0]) : NOP;
      @(negedge clk);
      #1;
      if (!clrn) begin
         mq.delete();
         m_infl = 1'b0;
         m_fpc  = RESET_PC;
      end else if (redirect) begin
         mq.delete();
         m_infl = 1'b0;
         m_fpc  = {redirect_pc[31:2], 2'b00};
      end else begin
         if (m_valid && instr_ready) void'(mq.pop_front());
         if (m_infl) mq.push_back(m_infl_pc);
         m_infl    = m_req;
         m_infl_pc = m_fpc;
         if (m_req) m_fpc = m_fpc + 32'd4;
      end
      imemdataout = o_req ? word_of(o_addr) : pc_t'($urandom());
   endtask

   task automatic do_reset();
      clrn     = 1'b0;
      redirect = 1'b0;
      tick();
      tick();
      clrn = 1'b1;
   endtask

   task automatic test_reset();
      clrn        = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'b1;
      redirect_pc = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (o_req !== 1'b0 || o_valid !== 1'b0 || o_instr !== NOP || o_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs c%0d: req=%b valid=%b instr=%h pc=%h, required 0/0/%h/0",
                     i, o_req, o_valid, o_instr, o_pc, NOP);
         end
      end
      clrn = 1'b1;
      tick();
      n_checks++;
      if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL reset_first_req: req=%b addr=%h, required 1 at %h", o_req, o_addr, RESET_PC);
      end
      n_checks++;
      if (o_valid !== 1'b0 || o_instr !== NOP || o_pc !== '0) begin
         n_fail++;
         $display("FAIL reset_release_out: valid=%b instr=%h pc=%h, required 0/%h/0",
                  o_valid, o_instr, o_pc, NOP);
      end
      n_checks++;
      if (o_imemclk !== 1'b1) begin
         n_fail++;
         $display("FAIL imemclk: got %b while clk high, required 1", o_imemclk);
      end
   endtask

   task automatic test_stream();
      do_reset();
      instr_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick();
         n_checks++;
         if (o_req !== 1'b1 || o_addr !== pc_t'(4 * n)) begin
            n_fail++;
            $display("FAIL stream_req c%0d: req=%b addr=%h, required 1 at %h", n, o_req, o_addr, 4 * n);
         end
         n_checks++;
         if (n >= 2) begin
            if (o_valid !== 1'b1 || o_pc !== pc_t'(4 * (n - 2)) ||
                o_instr !== word_of(pc_t'(4 * (n - 2)))) begin
               n_fail++;
               $display("FAIL stream_out c%0d: valid=%b pc=%h instr=%h, required 1 pc=%h", n,
                        o_valid, o_pc, o_instr, 4 * (n - 2));
            end
         end else if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_latency c%0d: valid=%b, required 0", n, o_valid);
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      instr_ready = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         n_checks++;
         if (o_req !== (n < 4) || o_addr !== ((n < 4) ? pc_t'(4 * n) : pc_t'(32'h10))) begin
            n_fail++;
            $display("FAIL full_issue c%0d: req=%b addr=%h, required req=%b", n, o_req, o_addr, n < 4);
         end
         if (n >= 2) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== '0) begin
               n_fail++;
               $display("FAIL full_head c%0d: valid=%b pc=%h, required 1 pc=0", n, o_valid, o_pc);
            end
         end
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (o_valid !== 1'b1 || o_pc !== pc_t'(4 * k) || o_instr !== word_of(pc_t'(4 * k))) begin
            n_fail++;
            $display("FAIL full_drain k%0d: valid=%b pc=%h instr=%h, required 1 pc=%h", k,
                     o_valid, o_pc, o_instr, 4 * k);
         end
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      instr_ready = 1'b0;
      repeat (6) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      n_checks++;
      if (o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_no_issue: req=%b, required 0", o_req);
      end
      redirect    = 1'b0;
      redirect_pc = pc_t'($urandom());
      tick();
      n_checks++;
      if (o_req !== 1'b1 || o_addr !== 32'h100 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_r1: req=%b addr=%h valid=%b, required 1 at 100 valid 0",
                  o_req, o_addr, o_valid);
      end
      tick();
      n_checks++;
      if (o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_r2: valid=%b, required 0", o_valid);
      end
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== word_of(32'h100)) begin
         n_fail++;
         $display("FAIL redir_r3: valid=%b pc=%h instr=%h, required 1 pc=100", o_valid, o_pc, o_instr);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      instr_ready = 1'b1;
      repeat (5) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect_pc = 32'h0000_0300;
      tick();
      n_checks++;
      if (o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_r1_req: req=%b, required 0", o_req);
      end
      redirect = 1'b0;
      for (int i = 2; i < 10; i++) begin
         tick();
         n_checks++;
         if (o_valid === 1'b1 && o_pc[31:8] === 24'h2) begin
            n_fail++;
            $display("FAIL b2b_stale c%0d: pc=%h visible, required none from 0x200", i, o_pc);
         end
         if (i < 4) begin
            n_checks++;
            if (o_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_gap c%0d: valid=%b pc=%h, required 0", i, o_valid, o_pc);
            end
         end
         if (i == 2) begin
            n_checks++;
            if (o_req !== 1'b1 || o_addr !== 32'h300) begin
               n_fail++;
               $display("FAIL b2b_req: req=%b addr=%h, required 1 at 300", o_req, o_addr);
            end
         end
         if (i == 4) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'h300) begin
               n_fail++;
               $display("FAIL b2b_first: valid=%b pc=%h, required 1 pc=300", o_valid, o_pc);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      instr_ready = 1'b1;
      repeat (6) tick();
      clrn = 1'b0;
      tick();
      n_checks++;
      if (o_req !== 1'b0 || o_valid !== 1'b0 || o_instr !== NOP || o_pc !== '0) begin
         n_fail++;
         $display("FAIL midreset_out: req=%b valid=%b instr=%h pc=%h, required 0/0/%h/0",
                  o_req, o_valid, o_instr, o_pc, NOP);
      end
      clrn = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         n_checks++;
         if (o_valid !== (n == 2) || (n == 2 && o_pc !== RESET_PC)) begin
            n_fail++;
            $display("FAIL midreset_refill c%0d: valid=%b pc=%h, required valid=%b", n, o_valid,
                     o_pc, n == 2);
         end
         if (n == 0) begin
            n_checks++;
            if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
               n_fail++;
               $display("FAIL midreset_req: req=%b addr=%h, required 1 at %h", o_req, o_addr, RESET_PC);
            end
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      instr_ready = 1'b1;
      repeat (3) tick();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF9;
      tick();
      redirect = 1'b0;
      for (int i = 1; i < 7; i++) begin
         tick();
         n_checks++;
         if (o_req !== 1'b1 || o_addr !== pc_t'(32'hFFFF_FFF8 + 32'(4 * (i - 1)))) begin
            n_fail++;
            $display("FAIL wrap_req r+%0d: req=%b addr=%h", i, o_req, o_addr);
         end
         if (i >= 3) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== pc_t'(32'hFFFF_FFF8 + 32'(4 * (i - 3)))) begin
               n_fail++;
               $display("FAIL wrap_out r+%0d: valid=%b pc=%h", i, o_valid, o_pc);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         clrn        = ($urandom_range(0, 199) != 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ?
                       32'hFFFF_FFF0 + pc_t'($urandom_range(0, 15)) : pc_t'($urandom());
         instr_ready = ($urandom_range(0, 9) < ((((n / 300) % 2) == 1) ? 2 : 8));
         tick();
         n_checks++;
         if (o_req !== m_req || o_addr !== m_addr) begin
            n_fail++;
            $display("FAIL rand_req c%0d: req=%b addr=%h, required req=%b addr=%h", n, o_req,
                     o_addr, m_req, m_addr);
         end
         n_checks++;
         if (o_valid !== m_valid || o_pc !== m_pc || o_instr !== m_instr) begin
            n_fail++;
            $display("FAIL rand_out c%0d: valid=%b pc=%h instr=%h, required %b %h %h", n, o_valid,
                     o_pc, o_instr, m_valid, m_pc, m_instr);
         end
      end
   endtask

   initial begin
      clrn        = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'b1;
      redirect_pc = '0;
      imemdataout = '0;
      test_reset();
      test_stream();
      test_full_stall();
      test_redirect_full();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
